// File: rtl/prbs_sync_checker.sv
// Self-synchronising receive checker for the x^8+x^6+x^5+x^4+1 PRBS stream.
// Seeds a shadow LFSR from the data, verifies it, then counts errors and drops lock above a windowed threshold.
module prbs_sync_checker #(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned ERR_THR  = 4,
    parameter int unsigned WIN_LEN  = 64
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_soft_reset,
    input  logic        i_valid,
    input  logic        i_data,
    output logic        o_lock,
    output logic        o_err_pulse,
    output logic [15:0] o_err_count,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  LOCK_CNT_L = 8'(LOCK_CNT);
    localparam logic [7:0]  ERR_THR_L  = 8'(ERR_THR);
    localparam logic [15:0] WIN_LEN_L  = 16'(WIN_LEN);

    state_t      state, state_n;
    logic [7:0]  s, s_n;
    logic [7:0]  bit_cnt, bit_cnt_n;
    logic [15:0] win_cnt, win_cnt_n;
    logic [7:0]  win_err, win_err_n;
    logic [15:0] err_count_n;
    logic        lock_n;
    logic        pulse_n;
    logic        pred;
    logic        mism;

    assign pred    = s[7] ^ s[5] ^ s[4] ^ s[3];
    assign mism    = i_data ^ pred;
    assign o_state = state;

    always_comb begin
        state_n     = state;
        s_n         = s;
        bit_cnt_n   = bit_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_count_n = o_err_count;
        lock_n      = o_lock;
        pulse_n     = 1'b0;

        if (i_valid) begin
            unique case (state)
                SEED: begin
                    s_n = {s[6:0], i_data};
                    if (bit_cnt == 8'd7) begin
                        bit_cnt_n = '0;
                        if (s_n != '0) begin
                            state_n = VERIFY;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
                VERIFY: begin
                    s_n = {s[6:0], i_data};
                    if (mism) begin
                        // The offending bit becomes the first bit of a fresh seed.
                        pulse_n   = 1'b1;
                        state_n   = SEED;
                        bit_cnt_n = 8'd1;
                    end else if (bit_cnt + 8'd1 == LOCK_CNT_L) begin
                        state_n   = LOCKED;
                        lock_n    = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    s_n       = {s[6:0], pred};
                    win_cnt_n = win_cnt + 16'd1;
                    if (mism) begin
                        pulse_n   = 1'b1;
                        win_err_n = win_err + 8'd1;
                        if (o_err_count != '1) begin
                            err_count_n = o_err_count + 16'd1;
                        end
                    end
                    // Unlock wins over a window close on the same bit.
                    if (win_err_n == ERR_THR_L) begin
                        state_n   = SEED;
                        lock_n    = 1'b0;
                        s_n       = '0;
                        bit_cnt_n = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else if (win_cnt_n == WIN_LEN_L) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end
                end
                default: begin
                    state_n   = SEED;
                    s_n       = '0;
                    bit_cnt_n = '0;
                    win_cnt_n = '0;
                    win_err_n = '0;
                    lock_n    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst || i_soft_reset) begin
            state       <= SEED;
            s           <= '0;
            bit_cnt     <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_lock      <= 1'b0;
            o_err_pulse <= 1'b0;
            o_err_count <= '0;
        end else begin
            state       <= state_n;
            s           <= s_n;
            bit_cnt     <= bit_cnt_n;
            win_cnt     <= win_cnt_n;
            win_err     <= win_err_n;
            o_lock      <= lock_n;
            o_err_pulse <= pulse_n;
            o_err_count <= err_count_n;
        end
    end

endmodule
